// File: rtl/address_joiner.sv
// address_joiner: burst address generator. Takes a starting
// (wordIndex, letterIndex) pair and a letter count. It emits one flat address
// {wordIndex, letterIndex} per accepted beat. Only one burst is in flight at a time.
//
// Build option: define ADDRESS_JOINER_WRAP_EN to let a burst wrap past the top
// of memory back to address 0. When it is left undefined, the all-ones address
// ends the burst early and `overrun` pulses for one cycle.
module address_joiner #(
   parameter int ROWINDEXBITS = 4,
   parameter int COLINDEXBITS = 2,
   parameter int LENGTHBITS   = ROWINDEXBITS + COLINDEXBITS + 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 reqValid,
   output logic                                 reqReady,
   input  logic [ROWINDEXBITS-1:0]              reqWordIndex,
   input  logic [COLINDEXBITS-1:0]              reqLetterIndex,
   input  logic [LENGTHBITS-1:0]                reqLength,
   output logic                                 addrValid,
   input  logic                                 addrReady,
   output logic [ROWINDEXBITS+COLINDEXBITS-1:0] address,
   output logic                                 addrLast,
   output logic                                 overrun
);

   localparam int ADDRBITS = ROWINDEXBITS + COLINDEXBITS;
   localparam logic [ADDRBITS-1:0] TOP_ADDR = '1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q;
   // The word/letter counters are held as one flat counter. Letter wrap then
   // carries into the word index by plain binary increment.
   logic [ADDRBITS-1:0]   addr_q;
   logic [LENGTHBITS-1:0] remaining_q;
   logic                  addr_valid_q;
   logic                  addr_last_q;
   logic                  overrun_q;

   logic [ADDRBITS-1:0]   start_addr;
   logic [ADDRBITS-1:0]   addr_d;
   logic                  start_last_d;
   logic                  next_last_d;
   logic                  trunc_d;

   assign start_addr = {reqWordIndex, reqLetterIndex};
   assign addr_d     = addr_q + ADDRBITS'(1);

`ifdef ADDRESS_JOINER_WRAP_EN
   // The counter simply rolls over to 0, so only the length decides the last beat.
   assign start_last_d = (reqLength == LENGTHBITS'(1));
   assign next_last_d  = (remaining_q == LENGTHBITS'(2));
   assign trunc_d      = 1'b0;
`else
   // The all-ones address is always a final beat. Reaching it with beats still
   // owed means the burst was cut short.
   assign start_last_d = (reqLength == LENGTHBITS'(1)) || (start_addr == TOP_ADDR);
   assign next_last_d  = (remaining_q == LENGTHBITS'(2)) || (addr_d == TOP_ADDR);
   assign trunc_d      = (addr_q == TOP_ADDR) && (remaining_q > LENGTHBITS'(1));
`endif

   // Requests are taken only in IDLE. The ready signal is held low while reset is high.
   assign reqReady  = (state_q == IDLE) && !reset;

   assign addrValid = addr_valid_q;
   assign address   = addr_q;
   assign addrLast  = addr_last_q;
   assign overrun   = overrun_q;

   // Burst FSM with registered outputs: load on accept, step on each accepted beat
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         addr_valid_q <= 1'b0;
         addr_last_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A zero-length request is consumed here without emitting anything
               if (reqValid && (reqLength != '0)) begin
                  addr_q       <= start_addr;
                  remaining_q  <= reqLength;
                  addr_valid_q <= 1'b1;
                  addr_last_q  <= start_last_d;
                  state_q      <= BURST;
               end
            end
            BURST: begin
               // addrValid is always high in BURST, so addrReady alone marks a beat
               if (addrReady) begin
                  if (addr_last_q) begin
                     addr_valid_q <= 1'b0;
                     addr_last_q  <= 1'b0;
                     overrun_q    <= trunc_d;
                     state_q      <= IDLE;
                  end else begin
                     addr_q       <= addr_d;
                     remaining_q  <= remaining_q - LENGTHBITS'(1);
                     addr_last_q  <= next_last_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_address_joiner.sv
// Testbench for address_joiner. It runs a vector table of directed bursts, hand
// sequences for reset and held-request cases, and randomized bursts. All of them are
// checked against a flat-arithmetic burst model.
module tb_address_joiner;

   localparam int RB    = 4;
   localparam int CB    = 2;
   localparam int LB    = RB + CB + 1;
   localparam int AB    = RB + CB;
   localparam int NADDR = 1 << AB;

`ifdef ADDRESS_JOINER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          reqValid;
   logic          reqReady;
   logic [RB-1:0] reqWordIndex;
   logic [CB-1:0] reqLetterIndex;
   logic [LB-1:0] reqLength;
   logic          addrValid;
   logic          addrReady;
   logic [AB-1:0] address;
   logic          addrLast;
   logic          overrun;

   always #5 clock = ~clock;

   address_joiner #(.ROWINDEXBITS(RB), .COLINDEXBITS(CB), .LENGTHBITS(LB)) dut (
      .clock          (clock),
      .reset          (reset),
      .reqValid       (reqValid),
      .reqReady       (reqReady),
      .reqWordIndex   (reqWordIndex),
      .reqLetterIndex (reqLetterIndex),
      .reqLength      (reqLength),
      .addrValid      (addrValid),
      .addrReady      (addrReady),
      .address        (address),
      .addrLast       (addrLast),
      .overrun        (overrun)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int w; int l; int len; int rmode;
      int first; int beats; int last; int ov;
   } vec_t;

   vec_t vecs[8];
   int   exp_q[$];
   int   exp_ov;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected beats: consecutive flat addresses from the start. They either roll over at
   // the top of memory, or stop there with an overrun when the length did not fit.
   function automatic void build_model(input int w, input int l, input int len);
      int start;
      start = w * (1 << CB) + l;
      exp_q.delete();
      for (int i = 0; i < len; i++) begin
         int a;
         a = start + i;
         if (a >= NADDR) begin
            if (WRAP) a = a % NADDR;
            else break;
         end
         exp_q.push_back(a);
      end
      exp_ov = (!WRAP && (start + len > NADDR)) ? 1 : 0;
   endfunction

   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: return logic'($urandom_range(0, 1));
      endcase
   endfunction

   // Present a request and return #1 after the edge where it was accepted
   task automatic start_req(input int w, input int l, input int len);
      int n;
      reqWordIndex   = RB'(w);
      reqLetterIndex = CB'(l);
      reqLength      = LB'(len);
      reqValid       = 1'b1;
      n = 0;
      while (!reqReady && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      chk("req_accept_wait", reqReady, 1);
      @(posedge clock); #1;
   endtask

   // Consume the expected beats, checking every cycle of the burst and the cycle after
   task automatic collect(input int rmode, output int nbeats, output int first,
                          output int lastaddr, output int ov);
      int cyc;
      cyc = 0; nbeats = 0; first = -1; lastaddr = -1; ov = 0;
      while (nbeats < exp_q.size() && cyc < 2000) begin
         addrReady = ready_for(rmode, cyc);
         chk("addrValid_busy", addrValid, 1);
         chk("reqReady_busy", reqReady, 0);
         chk("overrun_busy", overrun, 0);
         chk("address", address, exp_q[nbeats]);
         chk("addrLast", addrLast, (nbeats == exp_q.size() - 1) ? 1 : 0);
         if (addrReady) begin
            if (nbeats == 0) first = int'(address);
            lastaddr = int'(address);
            nbeats++;
         end
         @(posedge clock); #1;
         cyc++;
      end
      if (nbeats < exp_q.size()) chk("burst_timeout", nbeats, exp_q.size());
      addrReady = 1'b1;
      chk("addrValid_after", addrValid, 0);
      chk("reqReady_after", reqReady, 1);
      ov = int'(overrun);
   endtask

   initial begin
      int nb, fa, la, ov;

      vecs[0] = '{3, 1, 4, 0, 13, 4, 16, 0};
      vecs[1] = '{3, 1, 4, 1, 13, 4, 16, 0};
      vecs[3] = '{0, 0, 1, 0, 0, 1, 0, 0};
      vecs[4] = '{15, 3, 1, 1, 63, 1, 63, 0};
      vecs[6] = '{0, 0, 64, 1, 0, 64, 63, 0};
`ifdef ADDRESS_JOINER_WRAP_EN
      vecs[2] = '{15, 2, 4, 0, 62, 4, 1, 0};
      vecs[5] = '{15, 3, 2, 0, 63, 2, 0, 0};
      vecs[7] = '{10, 0, 127, 2, 40, 127, 38, 0};
`else
      vecs[2] = '{15, 2, 4, 0, 62, 2, 63, 1};
      vecs[5] = '{15, 3, 2, 0, 63, 1, 63, 1};
      vecs[7] = '{10, 0, 127, 2, 40, 24, 63, 1};
`endif

      reset = 1'b1; reqValid = 1'b0; addrReady = 1'b0;
      reqWordIndex = '0; reqLetterIndex = '0; reqLength = '0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rst_reqReady", reqReady, 0);
      chk("rst_addrValid", addrValid, 0);
      chk("rst_address", address, 0);
      chk("rst_addrLast", addrLast, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      #1;
      chk("rst_release_reqReady", reqReady, 1);
      @(posedge clock); #1;

      // Directed vector table
      foreach (vecs[i]) begin
         build_model(vecs[i].w, vecs[i].l, vecs[i].len);
         start_req(vecs[i].w, vecs[i].l, vecs[i].len);
         reqValid = 1'b0;
         collect(vecs[i].rmode, nb, fa, la, ov);
         chk("tbl_beats", nb, vecs[i].beats);
         chk("tbl_first", fa, vecs[i].first);
         chk("tbl_last", la, vecs[i].last);
         chk("tbl_overrun", ov, vecs[i].ov);
         @(posedge clock); #1;
         chk("tbl_overrun_once", overrun, 0);
      end

      // Zero-length request: consumed, nothing emitted, ready stays high
      reqWordIndex = 4'd5; reqLetterIndex = 2'd1; reqLength = '0; reqValid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk("len0_reqReady", reqReady, 1);
         chk("len0_addrValid", addrValid, 0);
         @(posedge clock); #1;
      end
      reqValid = 1'b0;
      chk("len0_addrValid_end", addrValid, 0);

      // Reset after the second beat of a length-8 burst
      addrReady = 1'b1;
      start_req(2, 0, 8);
      reqValid = 1'b0;
      chk("rstmid_beat0", address, 8);
      @(posedge clock); #1;
      chk("rstmid_beat1", address, 9);
      @(posedge clock); #1;
      addrReady = 1'b0;
      reset = 1'b1;
      #1;
      chk("rstmid_reqReady_in_reset", reqReady, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("rstmid_addrValid", addrValid, 0);
      chk("rstmid_reqReady", reqReady, 1);
      addrReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         chk("rstmid_quiet", addrValid, 0);
      end
      build_model(5, 3, 3);
      start_req(5, 3, 3);
      reqValid = 1'b0;
      collect(0, nb, fa, la, ov);
      chk("rstmid_new_first", fa, 23);
      chk("rstmid_new_beats", nb, 3);

      // reqValid held with new fields during a burst: taken right after the last beat
      build_model(1, 2, 5);
      start_req(1, 2, 5);
      reqWordIndex = 4'd7; reqLetterIndex = 2'd1; reqLength = 7'd6;
      collect(1, nb, fa, la, ov);
      chk("held_a_beats", nb, 5);
      chk("held_a_last", la, 10);
      build_model(7, 1, 6);
      @(posedge clock); #1;
      reqValid = 1'b0;
      collect(0, nb, fa, la, ov);
      chk("held_b_first", fa, 29);
      chk("held_b_beats", nb, 6);

      // Randomized bursts against the model
      for (int k = 0; k < 25; k++) begin
         int w, l, len;
         w = int'($urandom_range(0, 15));
         l = int'($urandom_range(0, 3));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                           : int'($urandom_range(0, 20));
         build_model(w, l, len);
         start_req(w, l, len);
         reqValid = 1'b0;
         if (len == 0) begin
            chk("rnd_len0_addrValid", addrValid, 0);
            chk("rnd_len0_reqReady", reqReady, 1);
         end else begin
            collect(2, nb, fa, la, ov);
            chk("rnd_beats", nb, exp_q.size());
            chk("rnd_overrun", ov, exp_ov);
            @(posedge clock); #1;
            chk("rnd_overrun_once", overrun, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/address_joiner.md
# address_joiner

Burst address generator, inverse of the memory address split: accepts a starting (wordIndex, letterIndex) pair plus a letter count and emits the corresponding sequence of flat memory addresses `{wordIndex, letterIndex}`, one per accepted beat. Sits in front of the row/column memory path, where its flat addresses are split back into word/letter indices. Valid/ready handshakes on both sides; one burst in flight at a time.

## Interface
- `ROWINDEXBITS`, default 4: word (row) index width; shared value from `MyParameters.vh`.
- `COLINDEXBITS`, default 2: letter (column) index width; shared value from `MyParameters.vh`.
- `LENGTHBITS`, default `ROWINDEXBITS+COLINDEXBITS+1`: burst length width; must be wide enough to express a full-memory burst.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `reqValid` in 1: burst request valid.
- `reqReady` out 1: request accepted when `reqValid && reqReady`.
- `reqWordIndex` in ROWINDEXBITS: starting word index.
- `reqLetterIndex` in COLINDEXBITS: starting letter index.
- `reqLength` in LENGTHBITS: number of addresses to emit.
- `addrValid` out 1: `address` valid.
- `addrReady` in 1: downstream accepts beat when `addrValid && addrReady`.
- `address` out ROWINDEXBITS+COLINDEXBITS: flat address, word index in the upper bits, letter index in the lower bits.
- `addrLast` out 1: current beat is the final beat of the burst.
- `overrun` out 1: one-cycle pulse when a burst is truncated at the top of memory; see Configuration.

## Operation
- FSM states: IDLE, BURST.
- IDLE: `reqReady`=1. On accept with `reqLength`≠0:
  - load word/letter counters and `remaining`=`reqLength`;
  - go to BURST.
- IDLE, accept with `reqLength`=0: request consumed, no beats emitted, remain IDLE.
- BURST: `reqReady`=0, `addrValid`=1, `address`={word, letter}, `addrLast`=(`remaining`==1).
- On each beat: letter increments. Letter wrap (all ones → 0) increments word.
  - `remaining` decrements.
  - If this was the last beat, go to IDLE.
- `addrReady` low: `address` and `addrLast` held stable; `addrValid` stays high (no retraction).
- Top-of-memory crossing (word and letter both all ones, beat accepted, `remaining`>1): handling depends on `ADDRESS_JOINER_WRAP_EN`.
- Reset values: state IDLE, `addrValid`=0, `address`=0, `addrLast`=0, `overrun`=0, counters 0. `reqReady`=0 while `reset` is high.
- Reset mid-burst: burst abandoned, no further beats, IDLE on the cycle after `reset` falls.
- `reqValid` in BURST is ignored (not accepted) until IDLE returns.

## Timing
- Request accepted in cycle N → first `addrValid`/`address` registered, visible in cycle N+1.
- Throughput: one address per cycle while `addrReady`=1.
- Last beat accepted in cycle M → `addrValid`=0 and `reqReady`=1 in cycle M+1; earliest next first beat is M+2.
- All outputs registered except `reqReady`, which is decoded from state and `reset`.

## Configuration
- `ADDRESS_JOINER_WRAP_EN` defined: on top-of-memory crossing, the counters wrap to address 0 and the burst continues for its full length; `overrun` is tied 0.
- `ADDRESS_JOINER_WRAP_EN` undefined: the all-ones address is forced as the final beat, with `addrLast`=1 on it regardless of `remaining`. When that beat is accepted, `overrun` pulses 1 for one cycle and the FSM returns to IDLE.

## Test plan
Defaults used: ROWINDEXBITS=4, COLINDEXBITS=2.
- Request word 3, letter 1, length 4, `addrReady` held 1 → addresses 13, 14, 15, 16 on consecutive cycles, starting the cycle after accept; `addrLast` only on 16 (letter wrap carries into word 4).
- Same request, `addrReady` toggled 1,0,0,1,… → each address held stable while stalled; 4 beats total, order unchanged, `addrValid` never drops mid-burst.
- Length 0 request → no `addrValid`; `reqReady` remains 1 every cycle.
- Word 15, letter 2, length 4:
  - macro defined → addresses 62, 63, 0, 1, with `overrun`=0;
  - undefined → addresses 62, 63 with `addrLast` on 63, `overrun` pulses once, then IDLE.
- `reset` asserted for one cycle after the 2nd beat of a length-8 burst → `addrValid`=0 during reset and after; `reqReady`=1 the cycle after reset falls; a new request then starts cleanly.
- `reqValid` held high with new fields during a burst → not accepted until the cycle after the last beat; second burst starts correctly.
